// File: rtl/reg_bus_poller.sv
// Read-only REG_BUS initiator: sweeps responder addresses 0..NUM_REGS-1 and mirrors them locally.
// Optional request timeout enabled by defining POLL_TIMEOUT_EN.

module reg_bus_poller_snap #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   q_o <= '0;
    else if (we_i) q_o <= d_i;
  end
endmodule

module reg_bus_poller #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 3,
  parameter int POLL_PERIOD = 1000,
  parameter int TIMEOUT     = 16
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           enable_i,
  input  logic                           start_i,
  input  logic                           clear_i,
  output logic [ADDR_WIDTH-1:0]          reg_addr_o,
  output logic                           reg_write_o,
  output logic [DATA_WIDTH-1:0]          reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]        reg_wstrb_o,
  output logic                           reg_valid_o,
  input  logic [DATA_WIDTH-1:0]          reg_rdata_i,
  input  logic                           reg_ready_i,
  input  logic                           reg_error_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] snap_o,
  output logic                           sweep_done_o,
  output logic                           alarm_o,
  output logic                           err_o,
  output logic                           timeout_o,
  output logic [7:0]                     err_cnt_o
);
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam logic [PW-1:0]         PLAST = PW'(POLL_PERIOD - 1);
  localparam logic [ADDR_WIDTH-1:0] ILAST = ADDR_WIDTH'(NUM_REGS - 1);

  if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_WIDTH) || POLL_PERIOD < 1 || TIMEOUT < 2)
    begin : g_bad_cfg
      $error("reg_bus_poller: illegal parameter combination");
    end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_GAP, S_DONE} state_t;
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } req_t;

  state_t                state, state_nxt;
  req_t                  req;
  logic [ADDR_WIDTH-1:0] idx;
  logic [PW-1:0]         pcnt;
  logic                  rsp_ok, rsp_err, tmo_hit, err_ev;
  logic                  err_q, tmo_q;
  logic [7:0]            ecnt_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] snap;

  // Error dominates ready; responses outside REQ are ignored.
  assign rsp_err = (state == S_REQ) && reg_error_i;
  assign rsp_ok  = (state == S_REQ) && reg_ready_i && !reg_error_i;
  assign err_ev  = rsp_err || tmo_hit;

`ifdef POLL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                    tcnt <= '0;
    else if (state == S_REQ && state_nxt == S_REQ)  tcnt <= tcnt + 1'b1;
    else                                            tcnt <= '0;
  end

  assign tmo_hit = (state == S_REQ) && !reg_ready_i && !reg_error_i &&
                   (tcnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_i) state_nxt = S_REQ;
              else if (enable_i) state_nxt = S_WAIT;
      S_WAIT: if (start_i) state_nxt = S_REQ;
              else if (!enable_i) state_nxt = S_IDLE;
              else if (pcnt == PLAST) state_nxt = S_REQ;
      S_REQ:  if (rsp_ok || rsp_err || tmo_hit) state_nxt = S_GAP;
      S_GAP:  state_nxt = (idx == ILAST) ? S_DONE : S_REQ;
      S_DONE: state_nxt = enable_i ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req.valid    = (state == S_REQ);
    req.addr     = idx;
    sweep_done_o = (state == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx  <= '0;
      pcnt <= '0;
    end else begin
      if (state == S_GAP && idx != ILAST) idx <= idx + 1'b1;
      else if (state == S_DONE)           idx <= '0;
      // Period counter only runs in WAIT, so every WAIT entry starts from zero.
      pcnt <= (state == S_WAIT) ? pcnt + 1'b1 : '0;
    end
  end

  // Same-cycle clear and new error leaves the new error recorded.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
      ecnt_q <= '0;
    end else begin
      if (rsp_err)      err_q <= 1'b1;
      else if (clear_i) err_q <= 1'b0;
      if (tmo_hit)      tmo_q <= 1'b1;
      else if (clear_i) tmo_q <= 1'b0;
      if (clear_i)                      ecnt_q <= err_ev ? 8'd1 : 8'd0;
      else if (err_ev && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_snap
    reg_bus_poller_snap #(.DATA_WIDTH(DATA_WIDTH)) u_snap (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .we_i   (rsp_ok && idx == ADDR_WIDTH'(i)),
      .d_i    (reg_rdata_i),
      .q_o    (snap[i])
    );
  end

  assign reg_addr_o  = req.addr;
  assign reg_valid_o = req.valid;
  assign reg_write_o = 1'b0;
  assign reg_wdata_o = '0;
  assign reg_wstrb_o = '0;
  assign snap_o      = snap;
  assign alarm_o     = snap[0][0];
  assign err_o       = err_q;
  assign timeout_o   = tmo_q;
  assign err_cnt_o   = ecnt_q;
endmodule
